sobel_grad_seq: RTL

- Sequencer that time-multiplexes one external sobel_add_nb add/sub unit to compute the Sobel gradient magnitude |Gx|+|Gy| of a 3x3 8-bit pixel window.
- Sits between the window buffer (valid/ready producer) and the pixel writer (valid/ready consumer).
- Drives the adder operands and the subtract select every cycle, and captures the adder result in internal registers.
- Fixed latency; one window in flight at a time.

---
 rtl/sobel_grad_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sobel_grad_seq.sv
// rtl/sobel_grad_seq.sv - Sobel |Gx|+|Gy| sequencer over one shared add/sub unit.
// Optional macro SOBEL_SEQ_SAT_EN saturates out_mag at 255 instead of truncating.
module sobel_grad_seq #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [71:0]  in_win,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_mag,
    output logic         busy,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_sub,
    input  logic [W-1:0] add_ans
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GX,
        S_ABSX,
        S_GY,
        S_ABSY,
        S_SUM,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [2:0]   r_step;
    logic [2:0]   w_step_nxt;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_mag_x;
    logic [71:0]  r_win_q;
    logic [7:0]   r_out_mag;
    logic [7:0]   w_mag_nxt;
    logic [W-1:0] w_px  [9];
    logic [W-1:0] w_px2 [9];
    logic [W-1:0] w_operand;
    logic         w_last_step;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_px[k]  = W'(r_win_q[8*k +: 8]);
            w_px2[k] = W'({r_win_q[8*k +: 8], 1'b0});
        end
    end

    // Steps 0-2 add the positive kernel column/row, steps 3-5 subtract the negative one.
    always_comb begin
        w_operand = '0;
        if (r_state == S_GX) begin
            case (r_step)
                3'd0:    w_operand = w_px[2];
                3'd1:    w_operand = w_px2[5];
                3'd2:    w_operand = w_px[8];
                3'd3:    w_operand = w_px[0];
                3'd4:    w_operand = w_px2[3];
                default: w_operand = w_px[6];
            endcase
        end else begin
            case (r_step)
                3'd0:    w_operand = w_px[6];
                3'd1:    w_operand = w_px2[7];
                3'd2:    w_operand = w_px[8];
                3'd3:    w_operand = w_px[0];
                3'd4:    w_operand = w_px2[1];
                default: w_operand = w_px[2];
            endcase
        end
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (r_state)
            S_GX, S_GY: begin
                add_a   = r_acc;
                add_b   = w_operand;
                add_sub = (r_step >= 3'd3);
            end
            S_ABSX, S_ABSY: begin
                if (r_acc[W-1]) begin
                    add_b   = r_acc;
                    add_sub = 1'b1;
                end else begin
                    add_a   = r_acc;
                end
            end
            S_SUM: begin
                add_a = r_mag_x;
                add_b = r_acc;
            end
            default: ;
        endcase
    end

    assign w_last_step = (r_step == 3'd5);

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = 3'd0;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = S_GX;
            S_GX: begin
                if (w_last_step) w_state_nxt = S_ABSX;
                else             w_step_nxt  = r_step + 3'd1;
            end
            S_ABSX: w_state_nxt = S_GY;
            S_GY: begin
                if (w_last_step) w_state_nxt = S_ABSY;
                else             w_step_nxt  = r_step + 3'd1;
            end
            S_ABSY: w_state_nxt = S_SUM;
            S_SUM:  w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef SOBEL_SEQ_SAT_EN
    assign w_mag_nxt = (add_ans > W'(255)) ? 8'hFF : add_ans[7:0];
`else
    assign w_mag_nxt = add_ans[7:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_step    <= 3'd0;
            r_acc     <= '0;
            r_mag_x   <= '0;
            r_win_q   <= '0;
            r_out_mag <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_win_q <= in_win;
                        r_acc   <= '0;
                    end
                end
                S_GX, S_GY, S_ABSY: r_acc <= add_ans;
                S_ABSX: begin
                    r_mag_x <= add_ans;
                    r_acc   <= '0;
                end
                S_SUM: begin
                    r_acc     <= add_ans;
                    r_out_mag <= w_mag_nxt;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_mag   = r_out_mag;

endmodule
